// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity select codes and the
// data-width decode used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_XNOR = 2'b00;
    localparam logic [1:0] PAR_XOR  = 2'b01;
    localparam logic [1:0] PAR_ZERO = 2'b10;
    localparam logic [1:0] PAR_ONE  = 2'b11;

    // cfg_bits encoding 00..11 maps to 5..8 data bits
    function automatic logic [3:0] bits_to_n(input logic [1:0] bits);
        return 4'd5 + {2'b00, bits};
    endfunction

    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        return {1'b1, bits};
    endfunction

    function automatic logic parity_bit(input logic [1:0] sel, input logic [7:0] data);
        logic p;
        case (sel)
            PAR_XNOR: p = ~^data;
            PAR_XOR:  p = ^data;
            PAR_ZERO: p = 1'b0;
            default:  p = 1'b1;
        endcase
        return p;
    endfunction

    // Data bits are shifted in at the MSB, so an N-bit char sits in [7:8-N]
    function automatic logic [7:0] align_data(input logic [7:0] shreg, input logic [1:0] bits);
        logic [3:0] shamt;
        shamt = 4'd8 - bits_to_n(bits);
        return shreg >> shamt;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchroniser for the asynchronous serial line plus falling-edge detect.
// Flops reset to 1 so a line held idle through reset never looks like a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic rx_i,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_s_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // The sampling point uses the retimed line one flop behind the edge
    // detector, so a start sample taken the cycle after the edge still
    // sees the start bit even at one clock per bit.
    assign rx_s = rx_s_q;
    assign fall = rx_s_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART serial receiver: start detection, mid-bit sampling, parity/stop checks
// and a single-entry valid/ready output register.
//  state     | meaning
//  ST_IDLE   | waiting for a falling edge on the synchronised line
//  ST_START  | half a bit period in, confirming the start bit
//  ST_DATA   | sampling data bits, LSB first
//  ST_PARITY | sampling and checking the parity bit
//  ST_STOP   | sampling the first stop bit, then delivering the char
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rx_i,
    output logic        busy_o,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_parity_sel_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic        err_o,
    output logic        frame_err_o,
    input  logic        err_clr_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i
);

    uart_state_e state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] target_q, target_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shreg_q;
    logic        err_q, frame_err_q;
    logic        valid_q;
    logic [7:0]  data_q;

    logic        rx_s;
    logic        rx_fall;
    logic        sample;
    logic        shift_en;
    logic        par_err_set;
    logic        frame_err_set;
    logic        deliver;
    logic [7:0]  rx_char;

    // Only the first stop bit is checked, so the stop-bit count has no effect here
    logic unused_cfg_stop_bits;
    assign unused_cfg_stop_bits = cfg_stop_bits_i;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .rx_i   (rx_i),
        .rx_s   (rx_s),
        .fall   (rx_fall)
    );

    assign sample  = (state_q != ST_IDLE) && (cnt_q == target_q);
    assign rx_char = align_data(shreg_q, cfg_bits_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        shift_en      = 1'b0;
        par_err_set   = 1'b0;
        frame_err_set = 1'b0;
        deliver       = 1'b0;
        if (!cfg_en_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state_d  = ST_START;
                        target_d = cfg_div_i >> 1;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        if (!rx_s) begin
                            state_d  = ST_DATA;
                            target_d = cfg_div_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shift_en = 1'b1;
                        if (bit_cnt_q == last_bit_idx(cfg_bits_i)) begin
                            state_d = cfg_parity_en_i ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        par_err_set = (rx_s != parity_bit(cfg_parity_sel_i, rx_char));
                        state_d     = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        frame_err_set = ~rx_s;
                        deliver       = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q     <= '0;
            target_q  <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            target_q <= target_d;
            if ((state_q == ST_IDLE) || sample) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (state_q == ST_IDLE) begin
                bit_cnt_q <= '0;
                shreg_q   <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shreg_q   <= {rx_s, shreg_q[7:1]};
            end
        end
    end

    // A char completing while the previous one is still unaccepted is dropped
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (!cfg_en_i) begin
            valid_q <= 1'b0;
        end else if (deliver && (!valid_q || rx_ready_i)) begin
            valid_q <= 1'b1;
            data_q  <= rx_char;
        end else if (valid_q && rx_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (par_err_set) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
            if (frame_err_set) begin
                frame_err_q <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;
    assign frame_err_o = frame_err_q;
    assign rx_valid_o  = valid_q;
    assign rx_data_o   = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built bit by bit from the line
// protocol and expected chars/flags are computed from the data and cfg alone.
module tb_uart_rx;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        rx_i;
    logic        busy_o;
    logic        cfg_en_i;
    logic [15:0] cfg_div_i;
    logic        cfg_parity_en_i;
    logic [1:0]  cfg_parity_sel_i;
    logic [1:0]  cfg_bits_i;
    logic        cfg_stop_bits_i;
    logic        err_o;
    logic        frame_err_o;
    logic        err_clr_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;

    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    logic [7:0]  last_rx = 8'h00;
    logic [7:0]  exp_q[$];

    always #5 clk_i = ~clk_i;

    uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .rx_i             (rx_i),
        .busy_o           (busy_o),
        .cfg_en_i         (cfg_en_i),
        .cfg_div_i        (cfg_div_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_sel_i (cfg_parity_sel_i),
        .cfg_bits_i       (cfg_bits_i),
        .cfg_stop_bits_i  (cfg_stop_bits_i),
        .err_o            (err_o),
        .frame_err_o      (frame_err_o),
        .err_clr_i        (err_clr_i),
        .rx_data_o        (rx_data_o),
        .rx_valid_o       (rx_valid_o),
        .rx_ready_i       (rx_ready_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every accepted char must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        if (rstn_i === 1'b1 && rx_valid_o === 1'b1 && rx_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_char: got %0h expected none", rx_data_o);
            end else begin
                check("rx_data", {24'h0, rx_data_o}, {24'h0, exp_q.pop_front()});
            end
            last_rx = rx_data_o;
            hs_count++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] data, input int n);
        return 8'(data % (1 << n));
    endfunction

    function automatic bit model_parity(input logic [7:0] data, input int n, input logic [1:0] sel);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(data[i]);
        case (sel)
            2'b00:   return (ones % 2) == 0;
            2'b01:   return (ones % 2) == 1;
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic set_cfg(input int n, input bit par_en, input logic [1:0] sel,
                           input bit two_stop, input int div);
        cfg_div_i        = 16'(div);
        cfg_bits_i       = 2'(n - 5);
        cfg_parity_en_i  = par_en;
        cfg_parity_sel_i = sel;
        cfg_stop_bits_i  = two_stop;
    endtask

    task automatic send_frame(input logic [7:0] data, input int n, input bit par_en,
                              input logic [1:0] sel, input bit bad_par, input bit bad_stop,
                              input bit two_stop, input int div);
        bit line[$];
        line.push_back(1'b0);
        for (int i = 0; i < n; i++) line.push_back(data[i]);
        if (par_en) line.push_back(model_parity(data, n, sel) ^ bad_par);
        line.push_back(!bad_stop);
        if (two_stop) line.push_back(1'b1);
        foreach (line[i]) begin
            rx_i = line[i];
            tick(div + 1);
        end
        rx_i = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] data, input int n, input bit par_en,
                             input logic [1:0] sel, input bit bad_par, input bit bad_stop,
                             input bit two_stop, input int div);
        int prev;
        int t;
        prev = hs_count;
        t    = 0;
        set_cfg(n, par_en, sel, two_stop, div);
        exp_q.push_back(model_char(data, n));
        send_frame(data, n, par_en, sel, bad_par, bad_stop, two_stop, div);
        while (hs_count == prev && t < 8 * (div + 1) + 20) begin
            tick(1);
            t++;
        end
        tick(3);
        check("delivered_count", hs_count - prev, 1);
        if (hs_count == prev) exp_q.delete();
        check("busy_after_frame", {31'h0, busy_o}, {31'h0, 1'b0});
        check("err_o", {31'h0, err_o}, {31'h0, par_en && bad_par});
        check("frame_err_o", {31'h0, frame_err_o}, {31'h0, bad_stop});
        err_clr_i = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
        check("err_o_cleared", {31'h0, err_o}, 32'h0);
        check("frame_err_o_cleared", {31'h0, frame_err_o}, 32'h0);
        tick(2 * (div + 1) + 2);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int t;
        int divs[7] = '{0, 1, 2, 3, 4, 7, 15};

        rstn_i     = 1'b0;
        rx_i       = 1'b1;
        cfg_en_i   = 1'b1;
        err_clr_i  = 1'b0;
        rx_ready_i = 1'b1;
        set_cfg(8, 1'b0, 2'b00, 1'b0, 15);
        tick(3);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_valid", {31'h0, rx_valid_o}, 32'h0);
        check("rst_data", {24'h0, rx_data_o}, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err_o}, 32'h0);
        rstn_i = 1'b1;
        tick(5);

        // 8N1, div 15
        run_frame(8'hA5, 8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 15);
        check("lit_A5", {24'h0, last_rx}, 32'hA5);

        // 8 data, parity sel 01, parity bit sent as 1 for 0x3C
        run_frame(8'h3C, 8, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 7);
        check("lit_3C", {24'h0, last_rx}, 32'h3C);

        // 5 data bits: upper bits on the wire are never sent
        run_frame(8'hF5, 5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 15);
        check("lit_15", {24'h0, last_rx}, 32'h15);

        // Stop bit low
        run_frame(8'h55, 8, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 15);
        check("lit_55", {24'h0, last_rx}, 32'h55);

        // Short glitch is rejected at the start-bit check
        set_cfg(8, 1'b0, 2'b00, 1'b0, 15);
        prev = hs_count;
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(1);
        check("glitch_busy_seen", {31'h0, busy_o}, 32'h1);
        tick(40);
        check("glitch_busy_idle", {31'h0, busy_o}, 32'h0);
        check("glitch_no_char", hs_count - prev, 0);
        check("glitch_valid", {31'h0, rx_valid_o}, 32'h0);
        check("glitch_err", {30'h0, err_o, frame_err_o}, 32'h0);

        // Overrun: second char is dropped while the first is held
        rx_ready_i = 1'b0;
        set_cfg(8, 1'b0, 2'b00, 1'b0, 3);
        exp_q.push_back(8'h11);
        prev = hs_count;
        send_frame(8'h11, 8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3);
        tick(12);
        send_frame(8'h22, 8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3);
        tick(12);
        check("overrun_valid", {31'h0, rx_valid_o}, 32'h1);
        check("overrun_data", {24'h0, rx_data_o}, 32'h11);
        rx_ready_i = 1'b1;
        t = 0;
        while (hs_count == prev && t < 20) begin
            tick(1);
            t++;
        end
        tick(2);
        check("overrun_accept_count", hs_count - prev, 1);
        check("overrun_accept_data", {24'h0, last_rx}, 32'h11);
        check("overrun_valid_drop", {31'h0, rx_valid_o}, 32'h0);
        check("overrun_queue_empty", exp_q.size(), 0);

        // Disable clears a held char but keeps sticky errors
        rx_ready_i = 1'b0;
        set_cfg(8, 1'b1, 2'b01, 1'b0, 3);
        send_frame(8'h5A, 8, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 3);
        t = 0;
        while (rx_valid_o !== 1'b1 && t < 40) begin
            tick(1);
            t++;
        end
        check("dis_valid_before", {31'h0, rx_valid_o}, 32'h1);
        check("dis_data_before", {24'h0, rx_data_o}, 32'h5A);
        check("dis_err_before", {31'h0, err_o}, 32'h1);
        cfg_en_i = 1'b0;
        tick(1);
        check("dis_valid_after", {31'h0, rx_valid_o}, 32'h0);
        check("dis_busy_after", {31'h0, busy_o}, 32'h0);
        check("dis_err_kept", {31'h0, err_o}, 32'h1);
        cfg_en_i   = 1'b1;
        rx_ready_i = 1'b1;
        err_clr_i  = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
        check("dis_err_cleared", {31'h0, err_o}, 32'h0);
        tick(4);

        // Randomised frames across all cfg combinations
        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            int         n;
            bit         pe;
            logic [1:0] sel;
            bit         bp;
            bit         bs;
            bit         ts;
            int         dv;
            d   = 8'($urandom);
            n   = int'($urandom_range(5, 8));
            pe  = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            bp  = ($urandom_range(0, 3) == 0);
            bs  = ($urandom_range(0, 4) == 0);
            ts  = 1'($urandom_range(0, 1));
            dv  = divs[$urandom_range(0, 6)];
            run_frame(d, n, pe, sel, bp, bs, ts, dv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
